midi_note_gate: RTL and testbench

Monophonic MIDI channel-voice parser that sits directly upstream of `adsr`. It consumes a byte stream from the UART receiver and drives the envelope's `gate` input. It also produces the note number and velocity used by the oscillator and amplitude stages. Note priority is last-note; running status is supported; real-time bytes are transparent.

---
 rtl/midi_note_gate.sv | 171 +++++++++++++++++
 tb/tb_midi_note_gate.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_note_gate.sv
// Monophonic MIDI channel-voice parser driving an envelope gate.
// Last-note priority, running status, transparent real-time bytes.
module midi_note_gate #(
    parameter int CHANNEL = 0,
    parameter bit OMNI    = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       gate,
    output logic [6:0] note,
    output logic [6:0] velocity,
    output logic       trigger
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_D1 = 2'd1,
        WAIT_D2 = 2'd2
    } state_t;

    localparam logic [3:0] CHAN_NIB = 4'(CHANNEL);

    state_t     state_r;
    logic [7:0] status_r;
    logic [6:0] d1_r;

    logic       is_sys_s;
    logic       is_stat_s;
    logic       is_data_s;
    logic [3:0] msg_type_s;
    logic       one_byte_s;
    logic       chan_match_s;
    logic       complete_s;
    logic [6:0] msg_d1_s;
    logic [6:0] msg_d2_s;
    logic       note_on_s;
    logic       note_off_s;
    logic       all_off_s;

    // Classify the incoming byte; real-time bytes fall through all classes.
    always_comb begin
        is_sys_s  = 1'b0;
        is_stat_s = 1'b0;
        is_data_s = 1'b0;
        if (rx_valid) begin
            if (rx_data[7:3] == 5'b11110) begin
                is_sys_s = 1'b1;
            end else if (rx_data[7] && (rx_data[7:4] != 4'hF)) begin
                is_stat_s = 1'b1;
            end else if (!rx_data[7]) begin
                is_data_s = 1'b1;
            end else begin
                is_data_s = 1'b0;
            end
        end else begin
            is_data_s = 1'b0;
        end
    end

    // Detect a completed message and decode the action it requests.
    always_comb begin
        msg_type_s   = status_r[7:4];
        one_byte_s   = (msg_type_s == 4'hC) || (msg_type_s == 4'hD);
        chan_match_s = OMNI || (status_r[3:0] == CHAN_NIB);
        complete_s   = 1'b0;
        msg_d1_s     = 7'd0;
        msg_d2_s     = 7'd0;
        note_on_s    = 1'b0;
        note_off_s   = 1'b0;
        all_off_s    = 1'b0;

        case (state_r)
            IDLE: begin
                complete_s = 1'b0;
            end
            WAIT_D1: begin
                complete_s = is_data_s && one_byte_s;
                msg_d1_s   = rx_data[6:0];
            end
            WAIT_D2: begin
                complete_s = is_data_s;
                msg_d1_s   = d1_r;
                msg_d2_s   = rx_data[6:0];
            end
            default: begin
                complete_s = 1'b0;
            end
        endcase

        if (complete_s && chan_match_s) begin
            case (msg_type_s)
                4'h9: begin
                    if (msg_d2_s != 7'd0) begin
                        note_on_s = 1'b1;
                    end else begin
                        note_off_s = 1'b1;
                    end
                end
                4'h8: begin
                    note_off_s = 1'b1;
                end
                4'hB: begin
                    if ((msg_d1_s == 7'd120) || (msg_d1_s == 7'd123)) begin
                        all_off_s = 1'b1;
                    end else begin
                        all_off_s = 1'b0;
                    end
                end
                default: begin
                    note_on_s = 1'b0;
                end
            endcase
        end else begin
            note_on_s = 1'b0;
        end
    end

    // Parser FSM with registered voice outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r  <= IDLE;
            status_r <= 8'h00;
            d1_r     <= 7'd0;
            gate     <= 1'b0;
            note     <= 7'd0;
            velocity <= 7'd0;
            trigger  <= 1'b0;
        end else begin
            trigger <= 1'b0;

            if (is_sys_s) begin
                state_r  <= IDLE;
                status_r <= 8'h00;
            end else if (is_stat_s) begin
                state_r  <= WAIT_D1;
                status_r <= rx_data;
            end else if (is_data_s) begin
                case (state_r)
                    IDLE: begin
                        state_r <= IDLE;
                    end
                    WAIT_D1: begin
                        d1_r    <= rx_data[6:0];
                        state_r <= one_byte_s ? WAIT_D1 : WAIT_D2;
                    end
                    WAIT_D2: begin
                        state_r <= WAIT_D1;
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end

            // Without a note stack only the most recent note may close the gate.
            if (note_on_s) begin
                gate     <= 1'b1;
                note     <= msg_d1_s;
                velocity <= msg_d2_s;
                trigger  <= 1'b1;
            end else if (note_off_s && gate && (msg_d1_s == note)) begin
                gate <= 1'b0;
            end else if (all_off_s) begin
                gate <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_note_gate.sv
// Self-checking bench for midi_note_gate: three instances (channel 0, channel 2,
// omni) compared every cycle against a queue-based message model.
module tb_midi_note_gate;

    logic       clk;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       gate_o [3];
    logic [6:0] note_o [3];
    logic [6:0] vel_o  [3];
    logic       trig_o [3];

    int n_assert = 0;
    int n_fail   = 0;

    // model state
    int         chan_m [3] = '{0, 2, 5};
    bit         omni_m [3] = '{1'b0, 1'b0, 1'b1};
    int         rs;
    logic [7:0] q [$];
    logic       mg [3];
    logic [6:0] mn [3];
    logic [6:0] mv [3];
    logic       mt [3];

    midi_note_gate #(.CHANNEL(0), .OMNI(1'b0)) u0 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .gate(gate_o[0]), .note(note_o[0]), .velocity(vel_o[0]), .trigger(trig_o[0]));
    midi_note_gate #(.CHANNEL(2), .OMNI(1'b0)) u1 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .gate(gate_o[1]), .note(note_o[1]), .velocity(vel_o[1]), .trigger(trig_o[1]));
    midi_note_gate #(.CHANNEL(5), .OMNI(1'b1)) u2 (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .gate(gate_o[2]), .note(note_o[2]), .velocity(vel_o[2]), .trigger(trig_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        rs = -1;
        q.delete();
        for (int k = 0; k < 3; k++) begin
            mg[k] = 1'b0; mn[k] = 7'd0; mv[k] = 7'd0; mt[k] = 1'b0;
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int typ;
        int need;
        if (b >= 8'hF8) return;
        if (b >= 8'hF0) begin rs = -1; q.delete(); return; end
        if (b >= 8'h80) begin rs = int'(b); q.delete(); return; end
        if (rs < 0) return;
        q.push_back(b);
        typ  = (rs >> 4) & 15;
        need = (typ == 12 || typ == 13) ? 1 : 2;
        if (q.size() < need) return;
        for (int k = 0; k < 3; k++) begin
            if (omni_m[k] || ((rs & 15) == chan_m[k])) begin
                if (typ == 9 && q[1] != 8'd0) begin
                    mg[k] = 1'b1; mn[k] = q[0][6:0]; mv[k] = q[1][6:0]; mt[k] = 1'b1;
                end else if (typ == 8 || typ == 9) begin
                    if (mg[k] && q[0][6:0] == mn[k]) mg[k] = 1'b0;
                end else if (typ == 11 && (q[0] == 8'd120 || q[0] == 8'd123)) begin
                    mg[k] = 1'b0;
                end
            end
        end
        q.delete();
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < 3; k++) begin
            n_assert++;
            assert (gate_o[k] === mg[k]) else begin
                n_fail++; $error("FAIL %s u%0d gate got %0b want %0b", tag, k, gate_o[k], mg[k]);
            end
            n_assert++;
            assert (note_o[k] === mn[k]) else begin
                n_fail++; $error("FAIL %s u%0d note got %h want %h", tag, k, note_o[k], mn[k]);
            end
            n_assert++;
            assert (vel_o[k] === mv[k]) else begin
                n_fail++; $error("FAIL %s u%0d velocity got %h want %h", tag, k, vel_o[k], mv[k]);
            end
            n_assert++;
            assert (trig_o[k] === mt[k]) else begin
                n_fail++; $error("FAIL %s u%0d trigger got %0b want %0b", tag, k, trig_o[k], mt[k]);
            end
        end
    endtask

    task automatic send(input logic [7:0] b, input logic v, input string tag);
        @(negedge clk);
        rx_data  = b;
        rx_valid = v;
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) mt[k] = 1'b0;
        if (v) model_byte(b);
        check_all(tag);
    endtask

    task automatic expect_u0(input logic g, input logic [6:0] n, input logic [6:0] v, input string tag);
        n_assert++;
        assert (gate_o[0] === g && note_o[0] === n && vel_o[0] === v) else begin
            n_fail++;
            $error("FAIL %s got g=%0b n=%h v=%h want g=%0b n=%h v=%h",
                   tag, gate_o[0], note_o[0], vel_o[0], g, n, v);
        end
    endtask

    logic [7:0] rb;
    logic       rv;
    int         r;

    initial begin
        reset    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b1;

        // basic note-on
        send(8'h90, 1'b1, "on_s");
        send(8'h3C, 1'b1, "on_d1");
        send(8'h64, 1'b1, "on_d2");
        expect_u0(1'b1, 7'h3C, 7'h64, "plan_on");
        send(8'h00, 1'b0, "on_idle");

        // note-off, then running-status velocity-0 note-on
        send(8'h80, 1'b1, "off_s");
        send(8'h3C, 1'b1, "off_d1");
        send(8'h00, 1'b1, "off_d2");
        expect_u0(1'b0, 7'h3C, 7'h64, "plan_off");
        send(8'h90, 1'b1, "rs_s");
        send(8'h3C, 1'b1, "rs_d1");
        send(8'h40, 1'b1, "rs_d2");
        send(8'h3C, 1'b1, "rs_v0_d1");
        send(8'h00, 1'b1, "rs_v0_d2");
        expect_u0(1'b0, 7'h3C, 7'h40, "plan_rs_v0");

        // last-note priority
        send(8'h90, 1'b1, "lp_s");
        send(8'h3C, 1'b1, "lp_a1");
        send(8'h64, 1'b1, "lp_a2");
        send(8'h40, 1'b1, "lp_b1");
        send(8'h50, 1'b1, "lp_b2");
        send(8'h80, 1'b1, "lp_off_s");
        send(8'h3C, 1'b1, "lp_off_a1");
        send(8'h00, 1'b1, "lp_off_a2");
        expect_u0(1'b1, 7'h40, 7'h50, "plan_lastnote");
        send(8'h40, 1'b1, "lp_off_b1");
        send(8'h00, 1'b1, "lp_off_b2");
        expect_u0(1'b0, 7'h40, 7'h50, "plan_lastnote_off");

        // interleaved real-time, then SysEx clears running status
        send(8'h90, 1'b1, "rt_s");
        send(8'hF8, 1'b1, "rt_f8");
        send(8'h45, 1'b1, "rt_d1");
        send(8'hFE, 1'b1, "rt_fe");
        send(8'h7F, 1'b1, "rt_d2");
        expect_u0(1'b1, 7'h45, 7'h7F, "plan_realtime");
        send(8'hF0, 1'b1, "sx_f0");
        send(8'h45, 1'b1, "sx_d1");
        send(8'h00, 1'b1, "sx_d2");
        expect_u0(1'b1, 7'h45, 7'h7F, "plan_sysex");

        // channel filter and all-notes-off
        send(8'h91, 1'b1, "ch1_s");
        send(8'h3C, 1'b1, "ch1_d1");
        send(8'h64, 1'b1, "ch1_d2");
        send(8'h92, 1'b1, "ch2_s");
        send(8'h3C, 1'b1, "ch2_d1");
        send(8'h64, 1'b1, "ch2_d2");
        send(8'hB2, 1'b1, "cc_s");
        send(8'h7B, 1'b1, "cc_d1");
        send(8'h00, 1'b1, "cc_d2");

        // retrigger same note with new velocity, gate stays high
        send(8'h90, 1'b1, "rtg_s");
        send(8'h30, 1'b1, "rtg_a1");
        send(8'h10, 1'b1, "rtg_a2");
        send(8'h30, 1'b1, "rtg_b1");
        send(8'h20, 1'b1, "rtg_b2");
        expect_u0(1'b1, 7'h30, 7'h20, "plan_retrigger");

        // asynchronous reset mid-message
        send(8'h90, 1'b1, "ar_s");
        send(8'h3C, 1'b1, "ar_d1");
        rx_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        @(negedge clk);
        reset = 1'b1;
        send(8'h50, 1'b1, "post_reset_data");
        send(8'h64, 1'b1, "post_reset_data2");

        // randomized byte stream
        for (int i = 0; i < 600; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 15) begin
                case ($urandom_range(0, 6))
                    0: rb = 8'h80;
                    1, 2: rb = 8'h90;
                    3: rb = 8'hB0;
                    4: rb = 8'hC0;
                    5: rb = 8'hD0;
                    default: rb = 8'hE0;
                endcase
                case ($urandom_range(0, 3))
                    0: rb[3:0] = 4'd0;
                    1: rb[3:0] = 4'd2;
                    2: rb[3:0] = 4'd5;
                    default: rb[3:0] = 4'($urandom_range(0, 15));
                endcase
            end else if (r < 22) begin
                rb = 8'(8'hF8 + $urandom_range(0, 7));
            end else if (r < 25) begin
                rb = 8'(8'hF0 + $urandom_range(0, 7));
            end else if (r < 32) begin
                rb = ($urandom_range(0, 1) == 0) ? 8'd120 : 8'd123;
            end else if (r < 45) begin
                rb = 8'h00;
            end else begin
                rb = 8'(8'd60 + $urandom_range(0, 4));
            end
            rv = ($urandom_range(0, 4) != 0);
            send(rb, rv, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
